// File: rtl/rca_pkg.sv
// rca_pkg: shared defaults, stage-count helper and configuration check for the pipelined adder.
`default_nettype none

package rca_pkg;

  localparam int N_DEFAULT   = 32;
  localparam int SEG_DEFAULT = 8;

  function automatic int stages(input int n, input int seg);
    return (seg > 0) ? (n / seg) : 1;
  endfunction

  function automatic bit cfg_ok(input int n, input int seg);
    return (seg >= 1) && (n >= seg) && ((n % seg) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rca_nbits.sv
// rca_nbits: combinational N-bit ripple-carry adder built from full-adder cells.
`default_nettype none

module rca_nbits #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] w_c;

  assign w_c[0] = cin;

  genvar i;
  for (i = 0; i < N; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[N];

endmodule

`default_nettype wire

// File: rtl/rca_pipelined.sv
// rca_pipelined: N-bit adder/subtractor split into SEG-bit ripple segments, one register stage
// per segment, with a global-stall valid/ready handshake.
`default_nettype none

module rca_pipelined
  import rca_pkg::*;
#(
  parameter int N   = N_DEFAULT,
  parameter int SEG = SEG_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         C_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         C_out,
  output logic         ovf
);

  localparam int STAGES = stages(N, SEG);

  if (!cfg_ok(N, SEG)) begin : g_cfg_err
    $error("rca_pipelined: N must be a non-zero multiple of SEG");
  end

  logic         w_advance;
  logic [N-1:0] w_yb_in;
  logic         w_cin_in;

  // Whole pipeline moves or holds together, so in_ready is one gate from out_ready.
  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;

  assign w_yb_in  = sub ? ~y : y;
  assign w_cin_in = sub | C_in;

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stage
    // SW: width of the operand bits not yet consumed when this stage adds.
    localparam int SW = (STAGES - k) * SEG;

    logic [SW-1:0]          w_src_x;
    logic [SW-1:0]          w_src_yb;
    logic                   w_src_c;
    logic                   w_src_v;
    logic [SEG-1:0]         w_sum;
    logic                   w_cout;
    logic [(k+1)*SEG-1:0]   w_res_next;

    logic                   r_v;
    logic                   r_c;
    logic [(k+1)*SEG-1:0]   r_res;

    if (k == 0) begin : g_src
      assign w_src_x    = x;
      assign w_src_yb   = w_yb_in;
      assign w_src_c    = w_cin_in;
      assign w_src_v    = in_valid;
      assign w_res_next = w_sum;
    end else begin : g_src
      assign w_src_x    = g_stage[k-1].g_fwd.r_x;
      assign w_src_yb   = g_stage[k-1].g_fwd.r_yb;
      assign w_src_c    = g_stage[k-1].r_c;
      assign w_src_v    = g_stage[k-1].r_v;
      assign w_res_next = {w_sum, g_stage[k-1].r_res};
    end

    rca_nbits #(
      .N(SEG)
    ) u_rca (
      .a    (w_src_x[SEG-1:0]),
      .b    (w_src_yb[SEG-1:0]),
      .cin  (w_src_c),
      .sum  (w_sum),
      .cout (w_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v   <= 1'b0;
        r_c   <= 1'b0;
        r_res <= '0;
      end else if (w_advance) begin
        r_v   <= w_src_v;
        r_c   <= w_cout;
        r_res <= w_res_next;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [SW-SEG-1:0] r_x;
      logic [SW-SEG-1:0] r_yb;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_x  <= '0;
          r_yb <= '0;
        end else if (w_advance) begin
          r_x  <= w_src_x[SW-1:SEG];
          r_yb <= w_src_yb[SW-1:SEG];
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic r_ovf;

      // Carry into the MSB is recovered from the MSB sum bit rather than tapping the ripple chain.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_ovf <= 1'b0;
        end else if (w_advance) begin
          r_ovf <= w_cout ^ (w_src_x[SEG-1] ^ w_src_yb[SEG-1] ^ w_sum[SEG-1]);
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_v;
  assign s         = g_stage[STAGES-1].r_res;
  assign C_out     = g_stage[STAGES-1].r_c;
  assign ovf       = g_stage[STAGES-1].g_last.r_ovf;

endmodule

`default_nettype wire
